// File: rtl/comparator_serial.sv
// Serial MSB-first magnitude comparator: DIGIT bits per cycle, one-hot gt/eq/lt result.
// Optional CMP_EARLY_EXIT_EN: finish on the first differing slice instead of after N steps.
module comparator_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST_STEP = CW'(N - 1);
  localparam logic [WIDTH-1:0] MSB_MASK  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             greater_q, greater_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;

  logic [DIGIT-1:0] slice_a, slice_b;
  logic             slice_diff;
  logic             finish;

  assign slice_a    = a_q[WIDTH-1 -: DIGIT];
  assign slice_b    = b_q[WIDTH-1 -: DIGIT];
  assign slice_diff = (slice_a != slice_b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      greater_q <= 1'b0;
      done_q    <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      greater_q <= greater_d;
      done_q    <= done_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    greater_d = greater_q;
    done_d    = 1'b0;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    finish    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Offset-binary mapping lets the unsigned slice compare give signed order
          a_d       = is_signed ? (A ^ MSB_MASK) : A;
          b_d       = is_signed ? (B ^ MSB_MASK) : B;
          cnt_d     = '0;
          decided_d = 1'b0;
          greater_d = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (!decided_q && slice_diff) begin
          decided_d = 1'b1;
          greater_d = (slice_a > slice_b);
        end
        a_d    = a_q << DIGIT;
        b_d    = b_q << DIGIT;
        cnt_d  = cnt_q + CW'(1);
        finish = (cnt_q == LAST_STEP);
`ifdef CMP_EARLY_EXIT_EN
        finish = finish | (!decided_q && slice_diff);
`endif
        if (finish) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          gt_d    = decided_d & greater_d;
          lt_d    = decided_d & ~greater_d;
          eq_d    = ~decided_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = done_q;
    gt   = gt_q;
    eq   = eq_q;
    lt   = lt_q;
  end

endmodule

// File: tb/tb_comparator_serial.sv
// Bench for comparator_serial: directed plan cases plus randomized traffic against a
// transaction-level reference (result from integer compare, latency from slice position).
module tb_comparator_serial;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int N     = WIDTH / DIGIT;
`ifdef CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] A, B;
  logic             is_signed;
  logic             busy, done, gt, eq, lt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  comparator_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .is_signed(is_signed),
    .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
  );

  always #5 clk = ~clk;

  // Result as {gt,eq,lt} from plain integer comparison
  function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                         input logic s);
    if (s) begin
      if ($signed(a) > $signed(b)) return 3'b100;
      if ($signed(a) < $signed(b)) return 3'b001;
      return 3'b010;
    end
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
    return 3'b010;
  endfunction

  // Cycles from accepted start to done
  function automatic int ref_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s);
    int ma, mb, sa, sb;
    if (!EE) return N;
    ma = int'(a) ^ (s ? (1 << (WIDTH-1)) : 0);
    mb = int'(b) ^ (s ? (1 << (WIDTH-1)) : 0);
    for (int i = 0; i < N; i++) begin
      sa = (ma >> (WIDTH - DIGIT*(i+1))) % (1 << DIGIT);
      sb = (mb >> (WIDTH - DIGIT*(i+1))) % (1 << DIGIT);
      if (sa != sb) return i + 1;
    end
    return N;
  endfunction

  bit       m_busy = 0, m_done = 0, m_gt = 0, m_eq = 0, m_lt = 0;
  int       m_rem  = 0;
  logic [2:0] m_pend = 3'b000;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_gt = 0; m_eq = 0; m_lt = 0; m_rem = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0;
          m_done = 1;
          {m_gt, m_eq, m_lt} = m_pend;
        end
      end else if (start) begin
        m_pend = ref_cmp(A, B, is_signed);
        m_rem  = ref_lat(A, B, is_signed);
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({busy, done, gt, eq, lt} !== {m_busy, m_done, m_gt, m_eq, m_lt}) begin
        fails++;
        $display("FAIL model t=%0t busy,done,gt,eq,lt got %b want %b", $time,
                 {busy, done, gt, eq, lt}, {m_busy, m_done, m_gt, m_eq, m_lt});
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Called at the negedge after the accept edge; returns at the negedge where done=1
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) check("done_timeout", 0, 1);
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, input logic [2:0] want_flags, input int want_lat);
    int lat;
    @(negedge clk);
    A = a; B = b; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check({name, "_flags"}, int'({gt, eq, lt}), int'(want_flags));
    check({name, "_lat"}, lat, want_lat);
    @(negedge clk);
    check({name, "_done_drop"}, int'(done), 0);
    check({name, "_hold"}, int'({gt, eq, lt}), int'(want_flags));
  endtask

  initial begin : main
    int lat;
    int d_idx[$];
    bit seen;
    rst_n = 1'b0; start = 1'b1; A = 8'h5A; B = 8'h3C; is_signed = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_outputs", int'({busy, done, gt, eq, lt}), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("start_after_release", int'(busy), 1);
    start = 1'b0;
    wait_done(lat);
    check("5A_3C_flags", int'({gt, eq, lt}), 3'b100);
    check("5A_3C_lat", lat, EE ? 1 : 4);
    @(negedge clk);
    check("5A_3C_done_drop", int'(done), 0);

    run_op("FF_FF", 8'hFF, 8'hFF, 1'b0, 3'b010, 4);
    run_op("10_11", 8'h10, 8'h11, 1'b0, 3'b001, 4);
    run_op("80_01_s", 8'h80, 8'h01, 1'b1, 3'b001, EE ? 1 : 4);
    run_op("80_01_u", 8'h80, 8'h01, 1'b0, 3'b100, EE ? 1 : 4);
    run_op("FF_FE_s", 8'hFF, 8'hFE, 1'b1, 3'b100, 4);
    run_op("C0_00", 8'hC0, 8'h00, 1'b0, 3'b100, EE ? 1 : 4);

    // start re-pulsed while busy is ignored
    @(negedge clk);
    A = 8'hFF; B = 8'hFE; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 8'h00; B = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    check("busy_ignore_flags", int'({gt, eq, lt}), 3'b100);
    @(negedge clk);
    check("busy_ignore_no_restart", int'(busy), 0);

    // start held through done cycles: back-to-back operations
    A = 8'hFF; B = 8'hFF; start = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (done === 1'b1) d_idx.push_back(c);
    end
    start = 1'b0;
    check("b2b_count", d_idx.size(), 3);
    if (d_idx.size() >= 3) begin
      check("b2b_gap1", d_idx[1] - d_idx[0], N + 1);
      check("b2b_gap2", d_idx[2] - d_idx[1], N + 1);
    end
    repeat (N + 2) @(negedge clk);

    // reset in the middle of an operation
    A = 8'hC0; B = 8'h00; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = done;
    @(negedge clk);
    seen |= done;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_outputs", int'({busy, done, gt, eq, lt}), 0);
    check("abort_done_seen", int'(seen), int'(EE));
    rst_n = 1'b1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start     = ($urandom_range(0, 2) == 0);
      is_signed = $urandom_range(0, 1);
      A         = WIDTH'($urandom);
      B         = WIDTH'($urandom);
      case ($urandom_range(0, 5))
        0: B = A;
        1: B = {A[WIDTH-1 -: DIGIT], B[WIDTH-DIGIT-1:0]};
        default: ;
      endcase
      rst_n = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    repeat (N + 2) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
